// File: rtl/alu_issue_ctrl_if.sv
// Request/response channels between decoder, issue controller and writeback.
// ALU_ISSUE_TAG_EN adds a 4-bit tag carried from request to response.
interface alu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_opcode;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
`ifdef ALU_ISSUE_TAG_EN
   logic [3:0]  req_tag;
   logic [3:0]  rsp_tag;

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
   );
   modport master (
      output req_valid, req_opcode, req_a, req_b, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
   );
`else
   modport slave (
      input  req_valid, req_opcode, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
   modport master (
      output req_valid, req_opcode, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );
`endif
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one op at a time to the 32-bit ALU and returns its result.
// Optional macro ALU_ISSUE_TAG_EN adds req_tag/rsp_tag to the interface.
module alu_issue_ctrl #(
   parameter int unsigned LOGIC_LAT = 1,
   parameter int unsigned ADD_LAT   = 1,
   parameter int unsigned MUL_LAT   = 4,
   parameter int unsigned FADD_LAT  = 3,
   parameter int unsigned FMUL_LAT  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_issue_ctrl_if.slave        bus,
   output logic [4:0]             alu_opcode,
   output logic [31:0]            alu_a,
   output logic [31:0]            alu_b,
   output logic                   alu_enable,
   input  logic [31:0]            alu_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_en, w_en_nxt;
   logic [4:0]  r_op, w_op_nxt;
   logic [31:0] r_a, w_a_nxt;
   logic [31:0] r_b, w_b_nxt;
   logic        r_vld, w_vld_nxt;
   logic [31:0] r_data, w_data_nxt;
   logic        r_err, w_err_nxt;
   logic        w_req_ready;
   logic [3:0]  w_op_lo;
   logic [3:0]  w_lat_m1;
`ifdef ALU_ISSUE_TAG_EN
   logic [3:0]  r_tag, w_tag_nxt;
`endif

   assign w_req_ready   = (r_state == S_IDLE) && !rst;
   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_vld;
   assign bus.rsp_data  = r_data;
   assign bus.rsp_err   = r_err;
   assign alu_enable    = r_en;
   assign alu_opcode    = r_op;
   assign alu_a         = r_a;
   assign alu_b         = r_b;
   assign w_op_lo       = bus.req_opcode[3:0];
`ifdef ALU_ISSUE_TAG_EN
   assign bus.rsp_tag   = r_tag;
`endif

   // Counter preload is latency-1 so EXEC lasts exactly LAT cycles
   always_comb begin
      w_lat_m1 = 4'(LOGIC_LAT - 1);
      unique case (1'b1)
         w_op_lo[3]:
            w_lat_m1 = 4'(LOGIC_LAT - 1);
         (w_op_lo[3:2] == 2'b00):
            w_lat_m1 = 4'(ADD_LAT - 1);
         (w_op_lo == 4'd4):
            w_lat_m1 = 4'(MUL_LAT - 1);
         (w_op_lo == 4'd5) || (w_op_lo == 4'd6):
            w_lat_m1 = 4'(FADD_LAT - 1);
         (w_op_lo == 4'd7):
            w_lat_m1 = 4'(FMUL_LAT - 1);
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_en_nxt    = r_en;
      w_op_nxt    = r_op;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_vld_nxt   = r_vld;
      w_data_nxt  = r_data;
      w_err_nxt   = r_err;
`ifdef ALU_ISSUE_TAG_EN
      w_tag_nxt   = r_tag;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (bus.req_valid && w_req_ready) begin
`ifdef ALU_ISSUE_TAG_EN
               w_tag_nxt = bus.req_tag;
`endif
               if (bus.req_opcode[4]) begin
                  w_state_nxt = S_DONE;
                  w_vld_nxt   = 1'b1;
                  w_err_nxt   = 1'b1;
                  w_data_nxt  = '0;
               end else begin
                  w_state_nxt = S_EXEC;
                  w_en_nxt    = 1'b1;
                  w_op_nxt    = bus.req_opcode;
                  w_a_nxt     = bus.req_a;
                  w_b_nxt     = bus.req_b;
                  w_cnt_nxt   = w_lat_m1;
               end
            end
         end
         S_EXEC: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_DONE;
               w_data_nxt  = alu_out;
               w_err_nxt   = 1'b0;
               w_vld_nxt   = 1'b1;
               w_en_nxt    = 1'b0;
               w_op_nxt    = '0;
               w_a_nxt     = '0;
               w_b_nxt     = '0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
               w_vld_nxt   = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_en    <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_vld   <= 1'b0;
         r_data  <= '0;
         r_err   <= 1'b0;
`ifdef ALU_ISSUE_TAG_EN
         r_tag   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_en    <= w_en_nxt;
         r_op    <= w_op_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_vld   <= w_vld_nxt;
         r_data  <= w_data_nxt;
         r_err   <= w_err_nxt;
`ifdef ALU_ISSUE_TAG_EN
         r_tag   <= w_tag_nxt;
`endif
      end
   end

endmodule
